// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary decoder: counts ones in a unipolar bitstream over a
// window of 2^WIDTH accepted samples and latches the saturated count.
module stoch_to_bin #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             TRIG,
   input  logic             RESET,
   input  logic             START,
   input  logic             CONT,
   input  logic             EN,
   input  logic             IN,
   output logic [WIDTH-1:0] OUT,
   output logic             VALID,
   output logic             BUSY
);

   localparam int unsigned CW = WIDTH + 1;
   localparam logic [WIDTH-1:0] LAST_SAMPLE = '1;
   localparam logic [WIDTH-1:0] MAX_VALUE   = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    ones_q,  ones_d;
   logic [WIDTH-1:0] samp_q,  samp_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic             valid_q, valid_d;
   logic             busy_q,  busy_d;
   logic [CW-1:0]    total;

   // State and datapath registers; reset discards any partial window.
   always_ff @(posedge TRIG) begin
      if (RESET) begin
         state_q <= IDLE;
         ones_q  <= '0;
         samp_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ones_q  <= ones_d;
         samp_q  <= samp_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, counting and window-completion logic.
   always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      samp_d  = samp_q;
      out_d   = out_q;
      valid_d = 1'b0;
      total   = ones_q + CW'(IN);

      case (state_q)
         IDLE: begin
            if (START || CONT) begin
               state_d = COUNT;
               ones_d  = '0;
               samp_d  = '0;
            end
         end
         COUNT: begin
            if (EN) begin
               if (samp_q == LAST_SAMPLE) begin
                  // An all-ones window reaches 2^WIDTH and saturates.
                  out_d   = total[WIDTH] ? MAX_VALUE : total[WIDTH-1:0];
                  valid_d = 1'b1;
                  ones_d  = '0;
                  samp_d  = '0;
                  if (!(CONT || START)) begin
                     state_d = IDLE;
                  end
               end else begin
                  samp_d = samp_q + WIDTH'(1);
                  ones_d = total;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == COUNT);
   end

   assign OUT   = out_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Scoreboard bench for stoch_to_bin: directed windows push expected values,
// a negedge monitor pops and compares on every VALID pulse.
module tb_stoch_to_bin;

   localparam int unsigned WIDTH = 8;
   localparam int N = 256;

   logic             TRIG  = 1'b0;
   logic             RESET = 1'b1;
   logic             START = 1'b0;
   logic             CONT  = 1'b0;
   logic             EN    = 1'b0;
   logic             IN    = 1'b0;
   logic [WIDTH-1:0] OUT;
   logic             VALID;
   logic             BUSY;

   int n_cmp = 0;
   int n_fail = 0;
   int valid_seen = 0;
   int pushes = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [N-1:0] lfsr_bits;

   stoch_to_bin #(.WIDTH(WIDTH)) dut (
      .TRIG (TRIG),
      .RESET(RESET),
      .START(START),
      .CONT (CONT),
      .EN   (EN),
      .IN   (IN),
      .OUT  (OUT),
      .VALID(VALID),
      .BUSY (BUSY)
   );

   always #5 TRIG = ~TRIG;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int v);
      exp_q.push_back(WIDTH'(v));
      pushes++;
   endtask

   task automatic tick();
      @(posedge TRIG);
      #1;
   endtask

   // Monitor: every VALID pulse must match the oldest expected value.
   always @(negedge TRIG) begin
      if (VALID) begin
         valid_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            check("valid_out", int'(OUT), int'(exp_q.pop_front()));
         end
      end
   end

   // Per-cycle stimulus for sample index k after the start edge.
   task automatic gen(input int mode, input int k);
      START = 1'b0;
      case (mode)
         0: begin EN = 1'b1; IN = 1'b1; end
         1: begin EN = 1'b1; IN = (k % 2 == 0); end
         2: begin EN = 1'b1; IN = 1'b0; end
         3: begin EN = (k % 2 == 0); IN = EN; end
         4: begin EN = (k % 2 == 0); IN = ~EN; end
         5: begin EN = 1'b1; IN = lfsr_bits[k]; end
         6: begin EN = 1'b1; IN = 1'b0; START = (k < 200); end
         default: begin EN = 1'b0; IN = 1'b0; end
      endcase
   endtask

   task automatic run_window(input int mode, input int exp_edges, input string name);
      int  k;
      bit  done;
      k = 0;
      done = 1'b0;
      START = 1'b1;
      tick();
      check({name, "_busy_after_start"}, int'(BUSY), 1);
      while (!done && k < 1200) begin
         gen(mode, k);
         tick();
         k++;
         if (VALID) done = 1'b1;
      end
      check({name, "_edges_to_valid"}, done ? k : -1, exp_edges);
      check({name, "_busy_at_valid"}, int'(BUSY), 0);
      START = 1'b0;
      EN = 1'b0;
      IN = 1'b0;
      tick();
      check({name, "_valid_one_cycle"}, int'(VALID), 0);
   endtask

   initial begin
      logic [7:0] lfsr;
      int pop;
      int v1;
      int v2;
      int busy_drop;

      // Reset state
      RESET = 1'b1;
      repeat (2) tick();
      check("reset_out", int'(OUT), 0);
      check("reset_valid", int'(VALID), 0);
      check("reset_busy", int'(BUSY), 0);
      RESET = 1'b0;
      tick();

      // Constant ones saturates; value holds afterwards
      push(255);
      run_window(0, 256, "all_ones");
      repeat (5) tick();
      check("out_hold", int'(OUT), 255);

      // Alternating and all-zero streams
      push(128);
      run_window(1, 256, "alternating");
      push(0);
      run_window(2, 256, "all_zeros");

      // EN stalls stretch the window; IN ignored on stall cycles
      push(255);
      run_window(3, 511, "en_toggle_ones");
      push(0);
      run_window(4, 511, "en_toggle_zeros");

      // Continuous mode: back-to-back windows with no BUSY gap
      push(255);
      push(64);
      v1 = -1;
      v2 = -1;
      busy_drop = 0;
      CONT = 1'b1;
      EN = 1'b1;
      IN = 1'b1;
      tick();
      check("cont_busy_after_start", int'(BUSY), 1);
      for (int k = 0; k < 512; k++) begin
         IN = (k < 256) ? 1'b1 : (k < 320);
         if (k == 511) CONT = 1'b0;
         tick();
         if (!BUSY && k < 511) busy_drop++;
         if (VALID) begin
            if (v1 < 0) v1 = k;
            else v2 = k;
         end
      end
      EN = 1'b0;
      IN = 1'b0;
      check("cont_first_valid_index", v1, 255);
      check("cont_valid_spacing", (v2 >= 0) ? v2 - v1 : -1, 256);
      check("cont_busy_drops", busy_drop, 0);
      check("cont_busy_after_end", int'(BUSY), 0);
      tick();

      // Reset mid-window discards the partial count
      START = 1'b1;
      tick();
      START = 1'b0;
      EN = 1'b1;
      IN = 1'b1;
      repeat (100) tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      EN = 1'b0;
      IN = 1'b0;
      check("midreset_out", int'(OUT), 0);
      check("midreset_valid", int'(VALID), 0);
      check("midreset_busy", int'(BUSY), 0);
      tick();
      push(0);
      run_window(6, 256, "start_held");

      // LFSR-encoded 100/256 with software popcount as reference
      lfsr = 8'h01;
      pop = 0;
      for (int i = 0; i < N; i++) begin
         lfsr_bits[i] = (lfsr < 8'd100);
         if (lfsr_bits[i]) pop++;
         lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      push(pop);
      run_window(5, 256, "lfsr100");
      check("lfsr_near_100", int'(OUT >= 8'd98 && OUT <= 8'd102), 1);

      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      check("valid_count", valid_seen, pushes);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
